// File: rtl/uart_hex_display.sv
// UART glue: decodes received ASCII hex into a shift-in display buffer, echoes every byte,
// and scans a common-anode 7-segment display. Define HEX_DISP_LZ_BLANK_EN for leading-zero blanking.
module uart_hex_display #(
    parameter int NDIG        = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int DBIT        = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DBIT-1:0]     rx_data,
    input  logic                rx_valid,
    output logic                tx_start,
    output logic [DBIT-1:0]     tx_data,
    input  logic                tx_done,
    output logic [6:0]          seg,
    output logic [NDIG-1:0]     an,
    output logic [4*NDIG-1:0]   value,
    output logic                echo_ovf
);

    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam logic [NDIG-1:0] AN_RST = ~(NDIG'(1));

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT} state_t;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        logic [6:0] g;
        g = 7'b1000000;
        case (n)
            4'h0: g = 7'b1000000;
            4'h1: g = 7'b1111001;
            4'h2: g = 7'b0100100;
            4'h3: g = 7'b0110000;
            4'h4: g = 7'b0011001;
            4'h5: g = 7'b0010010;
            4'h6: g = 7'b0000010;
            4'h7: g = 7'b1111000;
            4'h8: g = 7'b0000000;
            4'h9: g = 7'b0010000;
            4'hA: g = 7'b0001000;
            4'hB: g = 7'b0000011;
            4'hC: g = 7'b1000110;
            4'hD: g = 7'b0100001;
            4'hE: g = 7'b0000110;
            4'hF: g = 7'b0001110;
            default: g = 7'b1000000;
        endcase
        return g;
    endfunction

    state_t              r_state;
    state_t              w_state_next;
    logic [DBIT-1:0]     r_tx_data;
    logic                r_echo_ovf;
    logic [4*NDIG-1:0]   r_value;
    logic [CNT_W-1:0]    r_refresh_cnt;
    logic [IDX_W-1:0]    r_digit_idx;
    logic [NDIG-1:0]     r_an;
    logic [6:0]          r_seg;

    logic                w_hex_valid;
    logic                w_clear;
    logic [3:0]          w_rx_nibble;
    logic [3:0]          w_cur_nibble;
    logic [NDIG-1:0]     w_an_next;
    logic                w_blank;

    // NOTE: every signal written in always_comb gets a default first, so no path infers a latch.
    always_comb begin
        w_hex_valid = 1'b0;
        w_clear     = 1'b0;
        w_rx_nibble = 4'h0;
        if (rx_data >= DBIT'(8'h30) && rx_data <= DBIT'(8'h39)) begin
            w_hex_valid = 1'b1;
            w_rx_nibble = rx_data[3:0];
        end else if ((rx_data >= DBIT'(8'h41) && rx_data <= DBIT'(8'h46)) ||
                     (rx_data >= DBIT'(8'h61) && rx_data <= DBIT'(8'h66))) begin
            w_hex_valid = 1'b1;
            w_rx_nibble = rx_data[3:0] + 4'd9;
        end else if (rx_data == DBIT'(8'h0D) || rx_data == DBIT'(8'h1B)) begin
            w_clear = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_value <= '0;
        end else if (rx_valid) begin
            if (w_hex_valid)
                r_value <= {r_value[4*NDIG-5:0], w_rx_nibble};
            else if (w_clear)
                r_value <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (rx_valid) w_state_next = S_SEND;
            S_SEND:  w_state_next = S_WAIT;
            S_WAIT:  if (tx_done) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Bytes arriving while an echo is in flight are still decoded but never echoed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_data  <= '0;
            r_echo_ovf <= 1'b0;
        end else if (rx_valid) begin
            if (r_state == S_IDLE)
                r_tx_data <= rx_data;
            else
                r_echo_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_refresh_cnt <= '0;
            r_digit_idx   <= '0;
        end else if (r_refresh_cnt == CNT_W'(REFRESH_DIV - 1)) begin
            r_refresh_cnt <= '0;
            r_digit_idx   <= (r_digit_idx == IDX_W'(NDIG - 1)) ? '0 : r_digit_idx + IDX_W'(1);
        end else begin
            r_refresh_cnt <= r_refresh_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        w_cur_nibble = 4'h0;
        w_an_next    = '1;
        for (int i = 0; i < NDIG; i++) begin
            if (IDX_W'(i) == r_digit_idx) begin
                w_cur_nibble = r_value[4*i +: 4];
                w_an_next[i] = 1'b0;
            end
        end
    end

`ifdef HEX_DISP_LZ_BLANK_EN
    // Walk from the top digit down; a digit is blank when it and everything above it are zero.
    always_comb begin
        logic w_upper_zero;
        w_upper_zero = 1'b1;
        w_blank      = 1'b0;
        for (int i = NDIG - 1; i > 0; i--) begin
            w_upper_zero = w_upper_zero & (r_value[4*i +: 4] == 4'h0);
            if (IDX_W'(i) == r_digit_idx)
                w_blank = w_upper_zero;
        end
    end
`else
    assign w_blank = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_an  <= AN_RST;
            r_seg <= 7'b1000000;
        end else begin
            r_an  <= w_an_next;
            r_seg <= w_blank ? 7'b1111111 : glyph(w_cur_nibble);
        end
    end

    assign tx_start = (r_state == S_SEND);
    assign tx_data  = r_tx_data;
    assign echo_ovf = r_echo_ovf;
    assign value    = r_value;
    assign an       = r_an;
    assign seg      = r_seg;

endmodule

// File: tb/tb_uart_hex_display.sv
// Directed bench for uart_hex_display: echo scoreboard, decode model and scan checks.
module tb_uart_hex_display;

    localparam int NDIG = 4;
    localparam int RDIV = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        tx_done = 1'b0;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic [15:0] value;
    logic        echo_ovf;

    int          n_checks = 0;
    int          n_fails = 0;
    int          n_tx_start = 0;
    int          n_pushed = 0;
    logic [7:0]  exp_q[$];
    logic [15:0] exp_val = 16'h0000;

    logic [6:0]  glyph_tbl [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    uart_hex_display #(.NDIG(NDIG), .REFRESH_DIV(RDIV), .DBIT(8)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_start(tx_start), .tx_data(tx_data), .tx_done(tx_done),
        .seg(seg), .an(an), .value(value), .echo_ovf(echo_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every echo pulse must match the oldest byte expected to be echoed.
    always @(negedge clk) begin
        if (rst_n && tx_start === 1'b1) begin
            n_tx_start++;
            n_checks++;
            assert (exp_q.size() > 0) else begin
                n_fails++;
                $error("FAIL tx_start_unexpected: observed tx_data 0x%0h expected no echo", tx_data);
            end
            if (exp_q.size() > 0)
                check("tx_data", {24'h0, tx_data}, {24'h0, exp_q.pop_front()});
        end
    end

    function automatic logic [15:0] model(input logic [15:0] v, input logic [7:0] b);
        string       up;
        string       lo;
        logic [15:0] r;
        bit          hit;
        up  = "0123456789ABCDEF";
        lo  = "0123456789abcdef";
        r   = v;
        hit = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (!hit && (b == up[k] || b == lo[k])) begin
                r   = {v[11:0], 4'(k)};
                hit = 1'b1;
            end
        end
        if (!hit && (b == 8'h0D || b == 8'h1B))
            r = 16'h0000;
        return r;
    endfunction

    function automatic logic [6:0] exp_seg(input logic [3:0] an_pat);
        int         d;
        logic [6:0] g;
        d = 0;
        for (int i = 0; i < NDIG; i++)
            if (an_pat[i] == 1'b0) d = i;
        g = glyph_tbl[exp_val[4*d +: 4]];
`ifdef HEX_DISP_LZ_BLANK_EN
        if (d > 0 && (exp_val >> (4*d)) == 16'h0000)
            g = 7'b1111111;
`endif
        return g;
    endfunction

    // Drives one byte for one cycle; returns on the following falling edge.
    task automatic send_byte(input logic [7:0] b, input bit echoed);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        exp_val  = model(exp_val, b);
        if (echoed) begin
            exp_q.push_back(b);
            n_pushed++;
        end
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic wait_tx_start();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (tx_start === 1'b1) seen = 1'b1;
            else @(negedge clk);
        end
        check("tx_start_seen", {31'h0, seen}, 32'h1);
    endtask

    task automatic ack_echo();
        repeat (3) @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
    endtask

    task automatic send_echoed(input logic [7:0] b, input int gap);
        send_byte(b, 1'b1);
        wait_tx_start();
        ack_echo();
        repeat (gap) @(negedge clk);
    endtask

    task automatic check_scan();
        logic [3:0] prev;
        logic [3:0] exp_an;
        bit         moved;
        prev  = an;
        moved = 1'b0;
        for (int i = 0; i < 2*RDIV + 2 && !moved; i++) begin
            @(negedge clk);
            if (an !== prev) moved = 1'b1;
        end
        check("an_transition", {31'h0, moved}, 32'h1);
        exp_an = {prev[2:0], prev[3]};
        for (int j = 0; j < NDIG + 1; j++) begin
            for (int c = 0; c < RDIV; c++) begin
                check("an_scan", {28'h0, an}, {28'h0, exp_an});
                check("seg_scan", {25'h0, seg}, {25'h0, exp_seg(exp_an)});
                @(negedge clk);
            end
            exp_an = {exp_an[2:0], exp_an[3]};
        end
    endtask

    initial begin
        string s;
        int    base;

        repeat (2) @(negedge clk);
        check("rst_tx_start", {31'h0, tx_start}, 32'h0);
        check("rst_tx_data", {24'h0, tx_data}, 32'h0);
        check("rst_value", {16'h0, value}, 32'h0);
        check("rst_echo_ovf", {31'h0, echo_ovf}, 32'h0);
        check("rst_an", {28'h0, an}, 32'hE);
        check("rst_seg", {25'h0, seg}, 32'h40);
        rst_n = 1'b1;

        s = "1A2f";
        for (int i = 0; i < s.len(); i++)
            send_echoed(s[i], 190);
        check("value_1A2F", {16'h0, value}, 32'h1A2F);
        check("value_1A2F_model", {16'h0, value}, {16'h0, exp_val});
        check("ovf_clean", {31'h0, echo_ovf}, 32'h0);
        check_scan();

        s = "12345";
        for (int i = 0; i < s.len(); i++)
            send_echoed(s[i], 20);
        check("value_2345", {16'h0, value}, 32'h2345);

        send_echoed(8'h0D, 10);
        check("value_cr_clear", {16'h0, value}, 32'h0);
        send_echoed(8'h47, 10);
        check("value_non_hex", {16'h0, value}, 32'h0);

        send_echoed("7", 10);
        check("value_7", {16'h0, value}, 32'h7);
        check_scan();

        base = n_tx_start;
        send_byte("5", 1'b1);
        send_byte("6", 1'b0);
        repeat (5) @(negedge clk);
        check("ovf_one_echo", base + 1, n_tx_start);
        check("ovf_set", {31'h0, echo_ovf}, 32'h1);
        check("ovf_tx_data_held", {24'h0, tx_data}, 32'h35);
        check("ovf_value", {16'h0, value}, 32'h0756);
        check("ovf_value_model", {16'h0, value}, {16'h0, exp_val});
        ack_echo();
        repeat (10) @(negedge clk);
        check("ovf_sticky", {31'h0, echo_ovf}, 32'h1);

        send_byte("3", 1'b1);
        wait_tx_start();
        #2 rst_n = 1'b0;
        #1;
        exp_val = 16'h0000;
        check("arst_tx_start", {31'h0, tx_start}, 32'h0);
        check("arst_value", {16'h0, value}, 32'h0);
        check("arst_an", {28'h0, an}, 32'hE);
        check("arst_seg", {25'h0, seg}, 32'h40);
        check("arst_echo_ovf", {31'h0, echo_ovf}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        send_echoed("b", 10);
        check("post_rst_value", {16'h0, value}, 32'hB);
        check("post_rst_ovf", {31'h0, echo_ovf}, 32'h0);

        repeat (5) @(negedge clk);
        check("echo_queue_drained", exp_q.size(), 32'h0);
        check("tx_start_count", n_tx_start, n_pushed);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
